// File: rtl/serial_add_sched_if.sv
// serial_add_sched_if: request/result bundle for the shared bit-serial adder.
// The requester/consumer side uses the master modport, the scheduler the slave.
// Optional macro SERIAL_ADD_SUB_EN adds the per-request subtract flags and the
// echoed out_sub result flag.
interface serial_add_sched_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_sum;
    logic             out_id;
    logic             busy;
`ifdef SERIAL_ADD_SUB_EN
    logic             req0_sub;
    logic             req1_sub;
    logic             out_sub;
`endif

`ifdef SERIAL_ADD_SUB_EN
    modport master (
        output req0_valid, req0_a, req0_b, req0_sub,
        output req1_valid, req1_a, req1_b, req1_sub,
        output out_ready,
        input  req0_ready, req1_ready,
        input  out_valid, out_sum, out_id, out_sub, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub,
        input  req1_valid, req1_a, req1_b, req1_sub,
        input  out_ready,
        output req0_ready, req1_ready,
        output out_valid, out_sum, out_id, out_sub, busy
    );
`else
    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output out_ready,
        input  req0_ready, req1_ready,
        input  out_valid, out_sum, out_id, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  out_ready,
        output req0_ready, req1_ready,
        output out_valid, out_sum, out_id, busy
    );
`endif
endinterface

// File: rtl/serial_add_sched.sv
// serial_add_sched: round-robin scheduler sharing one 1-bit full-adder cell
// between two requesters. Operands are processed LSB-first, one bit per cycle,
// and the WIDTH+1-bit result is returned tagged with the requester id.
// Optional macro SERIAL_ADD_SUB_EN: per-request subtract (a-b via b inversion
// and an initial carry of 1), with the flag echoed on out_sub.
module serial_add_sched #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_add_sched_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic               last_grant_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   sum_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               id_q;
    logic               out_valid_q;
    logic               busy_q;
    logic               sub_q;

    logic               grant_id;
    logic               ready0;
    logic               ready1;
    logic               accept;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic               sel_sub;

    logic               bit_s;
    logic               carry_d;
    logic [WIDTH-1:0]   sum_d;
    logic               last_bit;

    // Round-robin grant: on a tie the requester that did not win last time goes.
    // Readys are additionally gated by rst_n so nothing is offered during reset.
    always_comb begin
        grant_id = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ~last_grant_q;
        end else if (bus.req1_valid) begin
            grant_id = 1'b1;
        end
        ready0 = rst_n && (state_q == IDLE) && bus.req0_valid && !grant_id;
        ready1 = rst_n && (state_q == IDLE) && bus.req1_valid &&  grant_id;
        accept = ready0 || ready1;
        sel_a  = grant_id ? bus.req1_a : bus.req0_a;
        sel_b  = grant_id ? bus.req1_b : bus.req0_b;
`ifdef SERIAL_ADD_SUB_EN
        sel_sub = grant_id ? bus.req1_sub : bus.req0_sub;
`else
        sel_sub = 1'b0;
`endif
    end

    // Shared full-adder cell on the current LSBs plus the shifted result word.
    always_comb begin
        bit_s    = a_q[0] ^ b_q[0] ^ carry_q;
        carry_d  = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
        sum_d    = {bit_s, sum_q[WIDTH-1:1]};
        last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Control FSM and serial datapath; result registers hold steady in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
            carry_q      <= 1'b0;
            cnt_q        <= '0;
            id_q         <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            sub_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q          <= sel_a;
                        b_q          <= sel_sub ? ~sel_b : sel_b;
                        carry_q      <= sel_sub;
                        sum_q        <= '0;
                        cnt_q        <= '0;
                        id_q         <= grant_id;
                        last_grant_q <= grant_id;
                        sub_q        <= sel_sub;
                        busy_q       <= 1'b1;
                        state_q      <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= carry_d;
                    sum_q   <= sum_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_sum    = {carry_q, sum_q};
    assign bus.out_id     = id_q;
    assign bus.busy       = busy_q;
`ifdef SERIAL_ADD_SUB_EN
    assign bus.out_sub    = sub_q;
`else
    // Subtract flag is never set without the option; keep it from dangling.
    logic unused_sub;
    assign unused_sub = sub_q;
`endif

endmodule

// File: tb/tb_serial_add_sched.sv
// Directed self-checking bench for serial_add_sched (WIDTH=8).
module tb_serial_add_sched;

    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    serial_add_sched_if #(.WIDTH(WIDTH)) bus ();

    serial_add_sched #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for out_valid, bounded; returns the number of edges waited.
    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!bus.out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    // Present one request, accept it, and check latency/result/consume.
    task automatic run_txn(input int who, input logic [7:0] a, input logic [7:0] b,
                           input logic [8:0] exp_sum, input string tag);
        int cyc;
        logic rdy;
        if (who == 0) begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
        end
        #1;
        cyc = 0;
        rdy = (who == 0) ? bus.req0_ready : bus.req1_ready;
        while (!rdy && cyc < 20) begin
            tick();
            cyc++;
            rdy = (who == 0) ? bus.req0_ready : bus.req1_ready;
        end
        chk({tag, "_ready"}, 32'(rdy), 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk({tag, "_ready_pulse"}, 32'(bus.req0_ready | bus.req1_ready), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        wait_out(cyc);
        chk({tag, "_latency"}, 32'(cyc), 32'(WIDTH));
        chk({tag, "_sum"}, 32'(bus.out_sum), 32'(exp_sum));
        chk({tag, "_id"}, 32'(bus.out_id), 32'(who));
`ifdef SERIAL_ADD_SUB_EN
        chk({tag, "_sub"}, 32'(bus.out_sub), 32'((who == 0) ? bus.req0_sub : bus.req1_sub));
`endif
        tick();
        chk({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int cyc;
        int viol;
        int exp_id;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
        bus.out_ready  = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
        bus.req0_sub = 1'b0;
        bus.req1_sub = 1'b0;
`endif
        // Reset state, with a request pending to show readys stay low
        bus.req0_valid = 1'b1;
        #3;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_sum",   32'(bus.out_sum),   32'd0);
        chk("rst_out_id",    32'(bus.out_id),    32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_ready0",    32'(bus.req0_ready), 32'd0);
        bus.req0_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single add and carry chains
        run_txn(0, 8'h5A, 8'h3C, 9'h096, "add0");
        run_txn(1, 8'hFF, 8'h01, 9'h100, "carry1");
        run_txn(1, 8'hFF, 8'hFF, 9'h1FE, "carry2");
        run_txn(0, 8'h00, 8'h00, 9'h000, "zero");

        // Alternation after a fresh reset with both requesters held valid
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        bus.req0_valid = 1'b1; bus.req0_a = 8'h12; bus.req0_b = 8'h34;
        bus.req1_valid = 1'b1; bus.req1_a = 8'h80; bus.req1_b = 8'h80;
        #1;
        for (int k = 0; k < 3; k++) begin
            exp_id = k % 2;
            chk("alt_ready0", 32'(bus.req0_ready), 32'(exp_id == 0));
            chk("alt_ready1", 32'(bus.req1_ready), 32'(exp_id == 1));
            tick();
            viol = 0;
            cyc = 0;
            while (!bus.out_valid && cyc < 40) begin
                if (bus.req0_ready || bus.req1_ready) viol++;
                tick();
                cyc++;
            end
            if (bus.req0_ready || bus.req1_ready) viol++;
            chk("alt_no_ready_busy", 32'(viol), 32'd0);
            chk("alt_latency", 32'(cyc), 32'(WIDTH));
            chk("alt_id", 32'(bus.out_id), 32'(exp_id));
            chk("alt_sum", 32'(bus.out_sum), (exp_id == 0) ? 32'h046 : 32'h100);
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();

        // Backpressure: hold DONE for 5 cycles with req0 pending
        bus.out_ready = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = 8'h01; bus.req0_b = 8'h02;
        #1;
        chk("bp_ready", 32'(bus.req0_ready), 32'd1);
        tick();
        wait_out(cyc);
        chk("bp_latency", 32'(cyc), 32'(WIDTH));
        viol = 0;
        for (int k = 0; k < 5; k++) begin
            if (bus.out_valid !== 1'b1 || bus.out_sum !== 9'h003 ||
                bus.out_id !== 1'b0 || bus.req0_ready !== 1'b0) viol++;
            tick();
        end
        chk("bp_hold", 32'(viol), 32'd0);
        chk("bp_still_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_release_busy",  32'(bus.busy), 32'd0);
        chk("bp_regrant", 32'(bus.req0_ready), 32'd1);
        bus.req0_a = 8'h7F; bus.req0_b = 8'h01;
        run_txn(0, 8'h7F, 8'h01, 9'h080, "bp_next");

        // Reset in the middle of RUN (cnt=3)
        bus.req0_valid = 1'b1; bus.req0_a = 8'hAA; bus.req0_b = 8'h55;
        #1;
        chk("mid_ready", 32'(bus.req0_ready), 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        tick(); tick(); tick();
        bus.req0_valid = 1'b1; bus.req0_a = 8'h0F; bus.req0_b = 8'h01;
        bus.req1_valid = 1'b1; bus.req1_a = 8'h33; bus.req1_b = 8'h33;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_busy",  32'(bus.busy), 32'd0);
        chk("mid_rst_sum",   32'(bus.out_sum), 32'd0);
        chk("mid_rst_id",    32'(bus.out_id), 32'd0);
        chk("mid_rst_ready", 32'(bus.req0_ready | bus.req1_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready0", 32'(bus.req0_ready), 32'd1);
        chk("post_rst_ready1", 32'(bus.req1_ready), 32'd0);
        bus.req1_valid = 1'b0;
        run_txn(0, 8'h0F, 8'h01, 9'h010, "post_rst");

`ifdef SERIAL_ADD_SUB_EN
        // Subtract option
        bus.req0_sub = 1'b1;
        run_txn(0, 8'h10, 8'h01, 9'h10F, "sub_nb");
        bus.req1_sub = 1'b1;
        run_txn(1, 8'h01, 8'h02, 9'h0FF, "sub_borrow");
        bus.req0_sub = 1'b0;
        bus.req1_sub = 1'b0;
        run_txn(0, 8'h10, 8'h01, 9'h011, "sub_off");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_add_sched.md
Name: serial_add_sched

Overview:
- Scheduler that shares one 1-bit full-adder cell between two requesters.
- The cell is the same sum/carry cell style used by the add2/add3 family in this library.
- Each requester submits a WIDTH-bit operand pair. The block arbitrates round-robin, runs the pair through the cell LSB-first (one bit per cycle), then returns a WIDTH+1-bit sum tagged with the requester id.
- It sits between small compute clients and the bit-serial adder to trade area for latency.

Parameters:
- WIDTH, 8: operand width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH)+1: bit-counter width (derived; do not override).

Ports:
- clk, input, 1: sole clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- req0_valid, input, 1: requester 0 has an operand pair.
- req0_ready, output, 1: requester 0 pair accepted this cycle.
- req0_a, input, WIDTH: requester 0 operand a.
- req0_b, input, WIDTH: requester 0 operand b.
- req1_valid, input, 1: requester 1 has an operand pair.
- req1_ready, output, 1: requester 1 pair accepted this cycle.
- req1_a, input, WIDTH: requester 1 operand a.
- req1_b, input, WIDTH: requester 1 operand b.
- out_valid, output, 1: result available.
- out_ready, input, 1: consumer accepts the result.
- out_sum, output, WIDTH+1: a+b; MSB is the final carry.
- out_id, output, 1: requester that owns out_sum.
- busy, output, 1: high in RUN or DONE.

Behaviour:
- Reset (async, rst_n=0), effective immediately, no clock needed:
  - state=IDLE; out_valid=0, out_sum=0, out_id=0, busy=0, req*_ready=0.
  - last_grant=1, so req0 wins the first tie.
  - Shift regs, carry and counter = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Grant is combinational. Only req0 valid -> req0. Only req1 valid -> req1. Both valid -> the one not equal to last_grant.
  - reqN_ready=1 only for the granted requester, only in IDLE.
  - On valid&ready: latch a, b into shift regs; carry=0; cnt=0; id=grant; last_grant=grant; go to RUN.
  - No valid: stay in IDLE, both readys 0.
- RUN, each cycle:
  - s = a[0]^b[0]^carry.
  - carry <= a[0]&b[0] | carry&(a[0]^b[0]).
  - s is shifted into the result reg from the MSB side; a and b shift right.
  - cnt++. When cnt==WIDTH-1, after that bit go to DONE and place the final carry as out_sum[WIDTH].
- DONE:
  - out_valid=1; out_sum and out_id stable.
  - Hold until out_ready=1, then go to IDLE and drop out_valid on the next edge.
- Latency: acceptance at edge T -> out_valid high after edge T+WIDTH (WIDTH cycles in RUN). With out_ready held high, throughput is one result per WIDTH+2 cycles.
- Readys are never asserted in RUN or DONE. A requester holding valid waits and must keep its operands stable.
- Arithmetic is unsigned. Overflow is not possible: the sum width is WIDTH+1. Wrap-around is not applicable.
- A valid drop while not granted is legal; no request is latched until the handshake.
- Reset mid-RUN or mid-DONE: the in-flight result is discarded, nothing is emitted, and the FSM restarts in IDLE with last_grant=1.
- out_ready while not in DONE is ignored.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- When defined:
  - Add inputs req0_sub and req1_sub (1 bit each), latched at acceptance.
  - When sub=1: b is inverted bitwise at latch, initial carry=1, and out_sum = {carry_out, a-b mod 2^WIDTH}. out_sum[WIDTH]=1 means no borrow (a>=b).
  - Add output out_sub echoing the latched flag; it resets to 0.
- When undefined: those ports do not exist and the block only adds.

Test Plan (WIDTH=8):
- Single add: req0 a=0x5A, b=0x3C, out_ready=1 -> req0_ready pulses 1 cycle; 8 cycles later out_valid=1, out_sum=0x096, out_id=0.
- Carry chain: req1 a=0xFF, b=0x01 -> out_sum=0x100, out_id=1; a=0xFF, b=0xFF -> 0x1FE.
- Simultaneous requests after reset, both held valid: first grant req0, second req1, third req0 (alternation). req1_ready stays 0 throughout req0's RUN and DONE.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, out_sum and out_id hold. No new grant occurs even with req0_valid=1. Release -> IDLE, then grant.
- Reset mid-RUN: assert rst_n=0 at cnt=3 -> all outputs 0 immediately. After release, req1 and req0 both valid -> req0 is granted and no stale result appears.
- With SERIAL_ADD_SUB_EN: a=0x10, b=0x01, sub=1 -> out_sum=0x10F. a=0x01, b=0x02, sub=1 -> out_sum=0x0FF.
